// File: rtl/rob_completion_arbiter.sv
// -----------------------------------------------------------------------------
// rob_completion_arbiter
//   Shares the single reorder-buffer completion port among NUM_REQ writeback
//   requesters (ALU, MUL, DIV, LSU). A round-robin scan starting at rr_ptr picks
//   at most one requester per cycle. The winner's payload is registered onto the
//   ROB completion interface, so it appears one cycle after the handshake. The
//   ROB port has no backpressure, so a grant can happen every cycle.
//
// Ports
//   clk_i                      clock
//   rst_i                      asynchronous active-high reset
//   req_valid_i [NUM_REQ]      requester i has a completion pending
//   req_ready_o [NUM_REQ]      combinational one-hot grant (zero on flush/reset)
//   req_rob_idx_i              packed ROB indices, slice i = [i*ROB_IDX_W +: ROB_IDX_W]
//   req_result_i               packed results, slice i = [i*CONFIG_XLEN +: CONFIG_XLEN]
//   req_exception_i [NUM_REQ]  exception flag per requester
//   req_exc_code_i             packed exception codes, slice i = [i*EXC_W +: EXC_W]
//   flush_i                    pipeline flush: blocks grants, clears output register
//   complete_*_o               registered completion toward the ROB
// -----------------------------------------------------------------------------
module rob_completion_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CONFIG_XLEN = 32,
  parameter int ROB_IDX_W   = 4,
  parameter int EXC_W       = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx_i,
  input  logic [NUM_REQ*CONFIG_XLEN-1:0] req_result_i,
  input  logic [NUM_REQ-1:0]           req_exception_i,
  input  logic [NUM_REQ*EXC_W-1:0]     req_exc_code_i,
  input  logic                         flush_i,
  output logic                         complete_valid_o,
  output logic [ROB_IDX_W-1:0]         complete_rob_idx_o,
  output logic [CONFIG_XLEN-1:0]       complete_result_o,
  output logic                         complete_exception_o,
  output logic [EXC_W-1:0]             complete_exception_code_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]       rr_ptr_r;
  logic [PTR_W-1:0]       win_s;
  logic                   found_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic                   any_grant_s;
  logic [PTR_W-1:0]       next_ptr_s;
  logic [ROB_IDX_W-1:0]   win_idx_s;
  logic [CONFIG_XLEN-1:0] win_result_s;
  logic                   win_exc_s;
  logic [EXC_W-1:0]       win_code_s;

  logic                   complete_valid_r;
  logic [ROB_IDX_W-1:0]   complete_rob_idx_r;
  logic [CONFIG_XLEN-1:0] complete_result_r;
  logic                   complete_exception_r;
  logic [EXC_W-1:0]       complete_code_r;

  // Round-robin scan: first valid requester at or after rr_ptr (mod NUM_REQ) wins.
  always_comb begin
    int scan_idx;
    scan_idx = 0;
    found_s  = 1'b0;
    win_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_r) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end else begin
        scan_idx = scan_idx;
      end
      if (!found_s && req_valid_i[PTR_W'(scan_idx)]) begin
        found_s = 1'b1;
        win_s   = PTR_W'(scan_idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant qualification: flush and reset both suppress the handshake entirely.
  always_comb begin
    grant_s = '0;
    if (found_s && !flush_i && !rst_i) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready_o = grant_s;
  assign any_grant_s = |grant_s;

  // Pointer advance past the winner, wrapping after the last requester.
  always_comb begin
    next_ptr_s = '0;
    if (int'(win_s) == NUM_REQ - 1) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_s + PTR_W'(1);
    end
  end

  // Winner payload selection; data is passed through untouched.
  always_comb begin
    win_idx_s    = req_rob_idx_i[int'(win_s)*ROB_IDX_W +: ROB_IDX_W];
    win_result_s = req_result_i[int'(win_s)*CONFIG_XLEN +: CONFIG_XLEN];
    win_exc_s    = req_exception_i[win_s];
    win_code_s   = req_exc_code_i[int'(win_s)*EXC_W +: EXC_W];
  end

  // Completion output register and round-robin pointer state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r             <= '0;
      complete_valid_r     <= 1'b0;
      complete_rob_idx_r   <= '0;
      complete_result_r    <= '0;
      complete_exception_r <= 1'b0;
      complete_code_r      <= '0;
    end else if (flush_i) begin
      // Flush empties the output register; the pointer keeps its position.
      complete_valid_r     <= 1'b0;
      complete_rob_idx_r   <= '0;
      complete_result_r    <= '0;
      complete_exception_r <= 1'b0;
      complete_code_r      <= '0;
    end else if (any_grant_s) begin
      rr_ptr_r             <= next_ptr_s;
      complete_valid_r     <= 1'b1;
      complete_rob_idx_r   <= win_idx_s;
      complete_result_r    <= win_result_s;
      complete_exception_r <= win_exc_s;
      complete_code_r      <= win_code_s;
    end else begin
      // Idle cycle: valid drops, payload holds its last value.
      complete_valid_r     <= 1'b0;
    end
  end

  assign complete_valid_o          = complete_valid_r;
  assign complete_rob_idx_o        = complete_rob_idx_r;
  assign complete_result_o         = complete_result_r;
  assign complete_exception_o      = complete_exception_r;
  assign complete_exception_code_o = complete_code_r;

endmodule
